// File: rtl/io_input_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : io_input_ctrl
// Description : Synchronises and debounces two external switch/button ports
//               for the CPU IO read mux (0x80 / 0x84). Optional macro
//               EDGE_CAPTURE_EN adds port-0 rising-edge flags plus an irq.
// Revision    : 1.0 - initial release
// ============================================================================
module io_input_ctrl #(
    parameter int WIDTH     = 8,
    parameter int DB_CYCLES = 16
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [WIDTH-1:0] raw0,
    input  logic [WIDTH-1:0] raw1,
    input  logic             rd_en,
    input  logic [31:0]      rd_addr,
    output logic [31:0]      in_port0,
    output logic [31:0]      in_port1,
    output logic             irq
);

    localparam logic [7:0] C_CNT_MAX = 8'(DB_CYCLES - 1);

    // Index 0 is port 0, index 1 is port 1.
    logic [1:0][WIDTH-1:0] sync1_q;
    logic [1:0][WIDTH-1:0] sync2_q;
    logic [1:0][WIDTH-1:0] stable_q;
    logic [1:0][WIDTH-1:0] stable_d;
    logic [1:0][7:0]       cnt_q;
    logic [1:0][7:0]       cnt_d;
    logic [WIDTH-1:0]      w_rise0;
    logic [WIDTH-1:0]      w_flags;
    logic                  w_unused_rd;

    // A mismatch keeps counting even if sync2 wanders; only equality clears it.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        for (int p = 0; p < 2; p++) begin
            if (sync2_q[p] == stable_q[p]) begin
                cnt_d[p] = '0;
            end else if (cnt_q[p] < C_CNT_MAX) begin
                cnt_d[p] = cnt_q[p] + 8'd1;
            end else begin
                stable_d[p] = sync2_q[p];
                cnt_d[p]    = '0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= {raw1, raw0};
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign w_rise0 = stable_d[0] & ~stable_q[0];

`ifdef EDGE_CAPTURE_EN
    logic [WIDTH-1:0] eflag_q;
    logic [WIDTH-1:0] eflag_d;
    logic             irq_q;
    logic             w_rd_clear;

    assign w_rd_clear = rd_en && rd_addr[7] && (rd_addr[6:2] == 5'd1);
    // A rise arriving with a clearing read survives the clear.
    assign eflag_d    = (w_rd_clear ? '0 : eflag_q) | w_rise0;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            eflag_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            eflag_q <= eflag_d;
            irq_q   <= |eflag_d;
        end
    end

    assign w_flags = eflag_q;
    assign irq     = irq_q;
`else
    assign w_flags = w_rise0 & '0;
    assign irq     = 1'b0;
`endif

    assign w_unused_rd = ^{rd_en, rd_addr};

    always_comb begin
        in_port0              = '0;
        in_port0[WIDTH-1:0]   = stable_q[0];
        in_port1              = '0;
        in_port1[WIDTH-1:0]   = stable_q[1];
        in_port1[15+WIDTH:16] = w_flags;
    end

endmodule
`default_nettype wire

// File: tb/tb_io_input_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_io_input_ctrl
// Description : Scoreboard bench for io_input_ctrl (WIDTH=8, DB_CYCLES=4)
//               with a run-length reference model and directed latency probes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_io_input_ctrl;

    localparam int C_W  = 8;
    localparam int C_DB = 4;

    logic           clk = 1'b0;
    logic           resetn;
    logic [C_W-1:0] raw0;
    logic [C_W-1:0] raw1;
    logic           rd_en;
    logic [31:0]    rd_addr;
    logic [31:0]    in_port0;
    logic [31:0]    in_port1;
    logic           irq;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [31:0] p0;
        logic [31:0] p1;
        logic        irq;
    } exp_t;

    exp_t sb_q[$];

    // Reference model: a raw value reaches the debouncer two edges later;
    // stable follows after DB consecutive edges of disagreement.
    logic [7:0] m_pipe0[$];
    logic [7:0] m_pipe1[$];
    logic [7:0] m_st[2];
    int         m_run[2];
    logic [7:0] m_flags;

    always #5 clk = ~clk;

    io_input_ctrl #(.WIDTH(C_W), .DB_CYCLES(C_DB)) dut (
        .clock    (clk),
        .resetn   (resetn),
        .raw0     (raw0),
        .raw1     (raw1),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .in_port0 (in_port0),
        .in_port1 (in_port1),
        .irq      (irq)
    );

    function automatic exp_t model(input logic [7:0] r0, input logic [7:0] r1,
                                   input logic re, input logic [31:0] a, input logic rn);
        exp_t       e;
        logic [7:0] seen[2];
        logic [7:0] old0;
        if (!rn) begin
            m_pipe0 = '{8'h00, 8'h00};
            m_pipe1 = '{8'h00, 8'h00};
            m_st[0] = '0; m_st[1] = '0;
            m_run[0] = 0; m_run[1] = 0;
            m_flags = '0;
        end else begin
            seen[0] = m_pipe0.pop_front(); m_pipe0.push_back(r0);
            seen[1] = m_pipe1.pop_front(); m_pipe1.push_back(r1);
            old0 = m_st[0];
            for (int p = 0; p < 2; p++) begin
                if (seen[p] == m_st[p]) begin
                    m_run[p] = 0;
                end else begin
                    m_run[p]++;
                    if (m_run[p] == C_DB) begin
                        m_st[p]  = seen[p];
                        m_run[p] = 0;
                    end
                end
            end
            if (re && a[7] && a[6:2] == 5'd1) m_flags = '0;
            m_flags = m_flags | (m_st[0] & ~old0);
        end
        e.p0 = {24'h0, m_st[0]};
`ifdef EDGE_CAPTURE_EN
        e.p1  = {8'h0, m_flags, 8'h0, m_st[1]};
        e.irq = |m_flags;
`else
        e.p1  = {24'h0, m_st[1]};
        e.irq = 1'b0;
`endif
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input logic [7:0] r0, input logic [7:0] r1, input logic re,
                        input logic [31:0] a, input logic rn);
        @(negedge clk);
        raw0 = r0; raw1 = r1; rd_en = re; rd_addr = a; resetn = rn;
        sb_q.push_back(model(r0, r1, re, a, rn));
    endtask

    task automatic sample();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_idle();
        step(8'h00, 8'h00, 1'b0, 32'h0, 1'b0);
        repeat (3) step(8'h00, 8'h00, 1'b0, 32'h0, 1'b1);
    endtask

    // Monitor: one expected entry per edge, compared just after that edge.
    initial begin
        exp_t e;
        forever begin
            sample();
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("sb_in_port0", in_port0, e.p0);
                chk("sb_in_port1", in_port1, e.p1);
                chk("sb_irq", {31'h0, irq}, {31'h0, e.irq});
            end
        end
    end

    initial begin
        logic [7:0]  r0, r1;
        logic        re, rn;
        logic [31:0] a;
        int          guard;
        raw0 = '0; raw1 = '0; rd_en = 1'b0; rd_addr = '0; resetn = 1'b0;

        // Reset release with A5 held: visible on the 6th edge.
        repeat (2) step(8'hA5, 8'h00, 1'b0, 32'h0, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            step(8'hA5, 8'h00, 1'b0, 32'h0, 1'b1);
            sample();
            chk("rst_release_lat", in_port0, (k < 6) ? 32'h0 : 32'hA5);
        end

        // Three-cycle glitch is rejected and the count starts over.
        reset_idle();
        repeat (3) step(8'h01, 8'h00, 1'b0, 32'h0, 1'b1);
        for (int k = 0; k < 8; k++) begin
            step(8'h00, 8'h00, 1'b0, 32'h0, 1'b1);
            sample();
            chk("glitch_reject", in_port0, 32'h0);
        end
        for (int k = 1; k <= 6; k++) begin
            step(8'h01, 8'h00, 1'b0, 32'h0, 1'b1);
            sample();
            chk("post_glitch_lat", in_port0, (k < 6) ? 32'h0 : 32'h1);
        end

        // Port 1 toggling then a hold of 01.
        reset_idle();
        for (int i = 0; i < 10; i++) step(8'h00, (i % 2 == 0) ? 8'h01 : 8'h00, 1'b0, 32'h0, 1'b1);
        for (int k = 1; k <= 6; k++) begin
            step(8'h00, 8'h01, 1'b0, 32'h0, 1'b1);
            sample();
            chk("toggle_hold_lat", in_port1, (k < 6) ? 32'h0 : 32'h1);
        end

        // Edge flag set, clearing read, and set-wins-over-clear.
        reset_idle();
        repeat (6) step(8'h01, 8'h01, 1'b0, 32'h0, 1'b1);
        sample();
`ifdef EDGE_CAPTURE_EN
        chk("flag_set_port1", in_port1, 32'h0001_0001);
        chk("flag_set_irq", {31'h0, irq}, 32'h1);
`else
        chk("flag_set_port1", in_port1, 32'h0000_0001);
        chk("flag_set_irq", {31'h0, irq}, 32'h0);
`endif
        step(8'h01, 8'h01, 1'b1, 32'h84, 1'b1);
        sample();
        chk("flag_clear_port1", in_port1, 32'h0000_0001);
        chk("flag_clear_irq", {31'h0, irq}, 32'h0);
        repeat (6) step(8'h00, 8'h01, 1'b0, 32'h0, 1'b1);
        repeat (6) step(8'h01, 8'h01, 1'b0, 32'h80, 1'b1);
        repeat (5) step(8'h03, 8'h01, 1'b0, 32'h0, 1'b1);
        step(8'h03, 8'h01, 1'b1, 32'h84, 1'b1);
        sample();
`ifdef EDGE_CAPTURE_EN
        chk("set_wins_port1", in_port1, 32'h0002_0001);
        chk("set_wins_irq", {31'h0, irq}, 32'h1);
`else
        chk("set_wins_port1", in_port1, 32'h0000_0001);
        chk("set_wins_irq", {31'h0, irq}, 32'h0);
`endif

        // Reset mid-count abandons the count.
        reset_idle();
        repeat (4) step(8'hFF, 8'h00, 1'b0, 32'h0, 1'b1);
        step(8'hFF, 8'h00, 1'b0, 32'h0, 1'b0);
        sample();
        chk("midreset_port0", in_port0, 32'h0);
        chk("midreset_port1", in_port1, 32'h0);
        chk("midreset_irq", {31'h0, irq}, 32'h0);
        for (int k = 1; k <= 6; k++) begin
            step(8'hFF, 8'h00, 1'b0, 32'h0, 1'b1);
            sample();
            chk("midreset_lat", in_port0, (k < 6) ? 32'h0 : 32'hFF);
        end

        // Randomised traffic: slow-changing ports, glitches, reads, resets.
        r0 = '0; r1 = '0;
        step(8'h00, 8'h00, 1'b0, 32'h0, 1'b0);
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 7) == 0) r0 = r0 ^ 8'($urandom);
            if ($urandom_range(0, 7) == 0) r1 = r1 ^ 8'($urandom);
            re = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 4))
                0:       a = 32'h84;
                1:       a = 32'h80;
                2:       a = 32'h184;
                3:       a = 32'h04;
                default: a = $urandom;
            endcase
            rn = ($urandom_range(0, 299) != 0);
            step(r0, r1, re, a, rn);
        end

        guard = 0;
        while (sb_q.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        #2;
        chk("scoreboard_drained", sb_q.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/io_input_ctrl.md
IO_INPUT_CTRL -- requirements
Module: io_input_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: bits per external input port, legal range 1..16.
REQ-002 Parameter DB_CYCLES, default 16: consecutive stable cycles needed to accept a change, legal range 2..255.
REQ-003 clock  input  1  single system clock; all state changes on its rising edge.
REQ-004 resetn  input  1  synchronous, active-low reset, sampled on the rising edge of clock.
REQ-005 raw0  input  WIDTH  external switch/button port 0; asynchronous to clock.
REQ-006 raw1  input  WIDTH  external switch/button port 1; asynchronous to clock.
REQ-007 rd_en  input  1  CPU memory-stage load of the IO region is in progress this cycle.
REQ-008 rd_addr  input  32  CPU memory-stage byte address (ALU result).
REQ-009 in_port0  output  32  debounced port 0, zero-extended; feeds the CPU IO read mux at address 0x80.
REQ-010 in_port1  output  32  debounced port 1 plus optional edge flags; feeds the CPU IO read mux at address 0x84.
REQ-011 irq  output  1  edge-capture interrupt request, level.

Function
REQ-012 Each raw bit SHALL pass through a 2-flop synchronizer (sync1 -> sync2) before any other use.
REQ-013 Each port SHALL hold a registered stable vector (stable0, stable1) and an 8-bit debounce counter (cnt0, cnt1).
REQ-014 Per port each edge: sync2 == stable -> cnt := 0; sync2 != stable and cnt < DB_CYCLES-1 -> cnt := cnt+1; sync2 != stable and cnt == DB_CYCLES-1 -> stable := sync2, cnt := 0.
REQ-015 Any change of sync2 while counting SHALL NOT restart the count; only a return to equality with stable clears cnt.
REQ-016 The counter SHALL never exceed DB_CYCLES-1 and SHALL never wrap.
REQ-017 Latency: a raw change held steady SHALL appear on in_port at the (2+DB_CYCLES)th rising edge after the edge that first samples it into sync1.
REQ-018 A sync2 deviation shorter than DB_CYCLES cycles SHALL leave stable unchanged.
REQ-019 in_port0 = {zeros, stable0}; in_port1[15:0] = {zeros, stable1}; all outputs registered, no combinational path from raw or rd_*.
REQ-020 Address decode: a read of in_port1 is rd_en=1 and rd_addr[7]=1 and rd_addr[6:2]=5'd1; other addresses have no side effect.

Reset
REQ-021 resetn=0 at an edge SHALL clear sync1, sync2, stable0, stable1, cnt0, cnt1, and all edge flags; in_port0=0, in_port1=0, irq=0 on the following cycle.
REQ-022 Reset asserted mid-count SHALL abandon the count; after release, counting restarts from 0 against stable=0.

Configuration
REQ-023 Macro EDGE_CAPTURE_EN SHALL, when defined, add a WIDTH-bit flag register eflag: bit i set on the edge where stable0[i] transitions 0->1.
REQ-024 With EDGE_CAPTURE_EN, in_port1[15+WIDTH:16] = eflag, irq = OR of eflag, and a read of in_port1 (REQ-020) clears eflag on the next edge.
REQ-025 With EDGE_CAPTURE_EN, a new rising edge on bit i in the same cycle as a clearing read SHALL leave eflag[i]=1 (set wins); other bits clear.
REQ-026 Without EDGE_CAPTURE_EN, no flag registers exist, in_port1[31:16]=0, irq is tied 0, and rd_en/rd_addr are unused.

Verification (WIDTH=8, DB_CYCLES=4)
REQ-027 Reset release with raw0=8'hA5 held -> in_port0=0 for 5 edges, in_port0=32'h000000A5 from edge 6.
REQ-028 raw0 bit0 pulsed high for 3 cycles from stable 0 -> in_port0 stays 0; cnt0 returns to 0.
REQ-029 raw1 toggles 0/1 for 10 cycles then holds 8'h01 -> in_port1[7:0]=8'h01 exactly 6 edges after the final hold begins.
REQ-030 EDGE_CAPTURE_EN, raw0 0->8'h01 -> in_port1=32'h00010001 and irq=1 once stable0 updates; rd_en=1, rd_addr=32'h84 one cycle -> next edge in_port1[31:16]=0, irq=0.
REQ-031 EDGE_CAPTURE_EN, clearing read at 0x84 on the same edge stable0 bit1 rises (bit0 flag already set) -> eflag=8'h02, irq=1.
REQ-032 resetn=0 for one edge at cnt0=2 -> all outputs 0 next cycle; raw0 held 8'hFF -> in_port0=32'hFF at edge 6 after release.
